// File: rtl/dither_pkg.sv
// dither_pkg: shared definitions for the ordered-dither datapath.
//   BAYER8       8x8 Bayer threshold matrix, values 0..63, indexed [row y][col x]
//   state_t      frame sequencer states
//   H/V_ACTIVE_DEF default frame geometry
package dither_pkg;

   localparam int H_ACTIVE_DEF = 320;
   localparam int V_ACTIVE_DEF = 240;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FLUSH,
      DONE
   } state_t;

   localparam logic [5:0] BAYER8 [8][8] = '{
      '{6'd0,  6'd32, 6'd8,  6'd40, 6'd2,  6'd34, 6'd10, 6'd42},
      '{6'd48, 6'd16, 6'd56, 6'd24, 6'd50, 6'd18, 6'd58, 6'd26},
      '{6'd12, 6'd44, 6'd4,  6'd36, 6'd14, 6'd46, 6'd6,  6'd38},
      '{6'd60, 6'd28, 6'd52, 6'd20, 6'd62, 6'd30, 6'd54, 6'd22},
      '{6'd3,  6'd35, 6'd11, 6'd43, 6'd1,  6'd33, 6'd9,  6'd41},
      '{6'd51, 6'd19, 6'd59, 6'd27, 6'd49, 6'd17, 6'd57, 6'd25},
      '{6'd15, 6'd47, 6'd7,  6'd39, 6'd13, 6'd45, 6'd5,  6'd37},
      '{6'd63, 6'd31, 6'd55, 6'd23, 6'd61, 6'd29, 6'd53, 6'd21}
   };

endpackage

// File: rtl/dither_scan_ctrl_if.sv
// dither_scan_ctrl_if: pixel-in and frame-buffer-write handshakes.
//   pix_valid/pix_ready/pix_data   gray pixel stream (source -> controller)
//   wr_valid/wr_ready/wr_addr/wr_data  packed 1-bpp bytes (controller -> buffer)
//   modport master: controller side; modport slave: source/frame-buffer side
interface dither_scan_ctrl_if #(
   parameter int AW = 14
);
   logic          pix_valid;
   logic          pix_ready;
   logic [7:0]    pix_data;
   logic          wr_valid;
   logic          wr_ready;
   logic [AW-1:0] wr_addr;
   logic [7:0]    wr_data;

   modport master (
      input  pix_valid, pix_data, wr_ready,
      output pix_ready, wr_valid, wr_addr, wr_data
   );

   modport slave (
      output pix_valid, pix_data, wr_ready,
      input  pix_ready, wr_valid, wr_addr, wr_data
   );
endinterface

// File: rtl/dither_threshold.sv
// dither_threshold: combinational ordered-dither decision for one pixel.
//   x, y     low 3 bits of the pixel coordinate (tile cell)
//   gray     8-bit gray value; only gray[7:2] is compared
//   pix_bit  1 when gray[7:2] exceeds the Bayer threshold of the cell
module dither_threshold
   import dither_pkg::*;
(
   input  logic [2:0] x,
   input  logic [2:0] y,
   input  logic [7:0] gray,
   output logic       pix_bit
);
   logic unused_gray_lsb;

   assign pix_bit         = (gray[7:2] > BAYER8[y][x]);
   assign unused_gray_lsb = ^gray[1:0];
endmodule

// File: rtl/dither_scan_ctrl.sv
// dither_scan_ctrl: frame sequencer for the ordered-dither path.
//   clk, rst_n   clock, asynchronous active-low reset
//   start        begin a frame (sampled in IDLE only)
//   abort        drop the current frame from any state
//   busy, done   busy in RUN/FLUSH; done pulses one cycle after the final byte
//   x, y         coordinate of the next pixel to be accepted
//   bus          pixel stream in, packed byte writes out (master side)
module dither_scan_ctrl
   import dither_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int AW       = 14
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               abort,
   output logic               busy,
   output logic               done,
   output logic [8:0]         x,
   output logic [7:0]         y,
   dither_scan_ctrl_if.master bus
);
   localparam logic [8:0] X_LAST = 9'(H_ACTIVE - 1);
   localparam logic [7:0] Y_LAST = 8'(V_ACTIVE - 1);

   state_t        state;
   logic [2:0]    bitcnt;
   logic [6:0]    pack;
   logic [AW-1:0] byte_addr;
   logic          wr_valid;
   logic [AW-1:0] wr_addr;
   logic [7:0]    wr_data;
   logic          pix_bit;
   logic          pix_ready;
   logic          accept;
   logic          last_pix;
   logic          wr_fire;

   dither_threshold u_threshold (
      .x       (x[2:0]),
      .y       (y[2:0]),
      .gray    (bus.pix_data),
      .pix_bit (pix_bit)
   );

   // Only one byte is buffered: the 8th bit of a group must wait until the
   // held byte leaves, otherwise it would overwrite the output register.
   assign pix_ready = (state == RUN) && !(bitcnt == 3'd7 && wr_valid && !bus.wr_ready);
   assign accept    = bus.pix_valid && pix_ready;
   assign last_pix  = (x == X_LAST) && (y == Y_LAST);
   assign wr_fire   = wr_valid && bus.wr_ready;

   assign bus.pix_ready = pix_ready;
   assign bus.wr_valid  = wr_valid;
   assign bus.wr_addr   = wr_addr;
   assign bus.wr_data   = wr_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         x         <= '0;
         y         <= '0;
         bitcnt    <= '0;
         pack      <= '0;
         byte_addr <= '0;
         wr_valid  <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
      end else begin
         done <= 1'b0;
         if (abort) begin
            state    <= IDLE;
            busy     <= 1'b0;
            wr_valid <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     state     <= RUN;
                     busy      <= 1'b1;
                     x         <= '0;
                     y         <= '0;
                     bitcnt    <= '0;
                     byte_addr <= '0;
                  end
               end
               RUN: begin
                  if (wr_fire)
                     wr_valid <= 1'b0;
                  if (accept) begin
                     pack   <= {pack[5:0], pix_bit};
                     bitcnt <= bitcnt + 3'd1;
                     // Raster order makes the running byte count equal to
                     // y*H_ACTIVE/8 + x/8 of the group's first pixel.
                     if (bitcnt == 3'd7) begin
                        wr_valid  <= 1'b1;
                        wr_data   <= {pack, pix_bit};
                        wr_addr   <= byte_addr;
                        byte_addr <= byte_addr + AW'(1);
                     end
                     if (last_pix) begin
                        state <= FLUSH;
                     end else if (x == X_LAST) begin
                        x <= '0;
                        y <= y + 8'd1;
                     end else begin
                        x <= x + 9'd1;
                     end
                  end
               end
               FLUSH: begin
                  if (wr_fire) begin
                     wr_valid <= 1'b0;
                     state    <= DONE;
                     busy     <= 1'b0;
                     done     <= 1'b1;
                  end
               end
               DONE: begin
                  state <= IDLE;
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_dither_scan_ctrl.sv
// tb_dither_scan_ctrl: scoreboard bench for dither_scan_ctrl.
//   dut_s: 16x2 frame (index 0), dut_f: 320x240 frame (index 1).
//   The pixel driver computes each expected byte from its own Bayer formula
//   and queues it; the write monitor pops and compares on every handshake.
module tb_dither_scan_ctrl;

   typedef struct packed {
      logic        last;
      logic [13:0] addr;
      logic [7:0]  data;
   } wr_exp_t;

   logic clk;
   logic rst_n;

   logic       st[2];
   logic       ab[2];
   logic       pv[2];
   logic [7:0] pd[2];
   logic       wr_rdy[2];

   logic        bz[2];
   logic        dn[2];
   logic        pr[2];
   logic        wv[2];
   logic [8:0]  xo[2];
   logic [7:0]  yo[2];
   logic [13:0] wa[2];
   logic [7:0]  wd[2];

   int n_vec = 0;
   int n_err = 0;

   wr_exp_t q0[$];
   wr_exp_t q1[$];
   logic    exp_done[2];
   int      wr_cnt[2];
   int      acc_cnt[2];
   logic [7:0] seen0[4];
   logic    ff_mode;

   int         bx[2];
   int         by[2];
   logic [7:0] grp[2];
   int         gaddr[2];

   int         c0, c1, a0;
   logic [13:0] sa;
   logic [7:0]  sd;

   dither_scan_ctrl_if #(.AW(14)) bus_s ();
   dither_scan_ctrl_if #(.AW(14)) bus_f ();

   assign bus_s.pix_valid = pv[0];
   assign bus_s.pix_data  = pd[0];
   assign bus_s.wr_ready  = wr_rdy[0];
   assign pr[0] = bus_s.pix_ready;
   assign wv[0] = bus_s.wr_valid;
   assign wa[0] = bus_s.wr_addr;
   assign wd[0] = bus_s.wr_data;

   assign bus_f.pix_valid = pv[1];
   assign bus_f.pix_data  = pd[1];
   assign bus_f.wr_ready  = wr_rdy[1];
   assign pr[1] = bus_f.pix_ready;
   assign wv[1] = bus_f.wr_valid;
   assign wa[1] = bus_f.wr_addr;
   assign wd[1] = bus_f.wr_data;

   dither_scan_ctrl #(.H_ACTIVE(16), .V_ACTIVE(2), .AW(14)) dut_s (
      .clk   (clk),
      .rst_n (rst_n),
      .start (st[0]),
      .abort (ab[0]),
      .busy  (bz[0]),
      .done  (dn[0]),
      .x     (xo[0]),
      .y     (yo[0]),
      .bus   (bus_s)
   );

   dither_scan_ctrl #(.H_ACTIVE(320), .V_ACTIVE(240), .AW(14)) dut_f (
      .clk   (clk),
      .rst_n (rst_n),
      .start (st[1]),
      .abort (ab[1]),
      .busy  (bz[1]),
      .done  (dn[1]),
      .x     (xo[1]),
      .y     (yo[1]),
      .bus   (bus_f)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Bayer 8x8 by bit interleave: reversed bits of (x^y) and y.
   function automatic logic [5:0] bayer(input int xx, input int yy);
      logic [2:0] a;
      logic [2:0] b;
      a = 3'(xx ^ yy);
      b = 3'(yy);
      return {a[0], b[0], a[1], b[1], a[2], b[2]};
   endfunction

   function automatic void push_exp(input int d, input wr_exp_t e);
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
   endfunction

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         wr_exp_t e;
         if (exp_done[d] || dn[d])
            chk(d == 0 ? "done_s" : "done_f", 32'(dn[d]), 32'(exp_done[d]));
         exp_done[d] = 1'b0;
         if (pv[d] && pr[d])
            acc_cnt[d]++;
         if (wv[d] && wr_rdy[d]) begin
            wr_cnt[d]++;
            if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
               chk("unexpected_wr", 32'(wa[d]), 32'h7fff_ffff);
            end else begin
               e = (d == 0) ? q0.pop_front() : q1.pop_front();
               chk("wr_addr", 32'(wa[d]), 32'(e.addr));
               chk("wr_data", 32'(wd[d]), 32'(e.data));
               exp_done[d] = e.last;
            end
            if (d == 0 && wa[0] < 14'd4)
               seen0[wa[0][1:0]] = wd[0];
            if (d == 1 && ff_mode && (wa[1] % 14'd40) == 14'd0)
               chk("ff_col0_byte", 32'(wd[1]), ((wa[1] / 14'd40) % 14'd8 == 14'd7) ? 32'h7F : 32'hFF);
         end
      end
   end

   task automatic start_frame(input int d);
      @(posedge clk); #1;
      st[d]  = 1'b1;
      bx[d]  = 0;
      by[d]  = 0;
      grp[d] = '0;
      @(posedge clk); #1;
      st[d] = 1'b0;
      chk("start_ready", 32'(pr[d]), 32'd1);
      chk("start_busy", 32'(bz[d]), 32'd1);
   endtask

   // mode 0: constant gray g; mode 1: random gray
   task automatic drive(input int d, input int n, input int mode, input logic [7:0] g);
      int   hact;
      int   vact;
      int   c;
      logic acc;
      logic b;
      logic [7:0] gv;
      wr_exp_t e;
      hact = (d == 0) ? 16 : 320;
      vact = (d == 0) ? 2 : 240;
      for (int i = 0; i < n; i++) begin
         gv    = (mode == 0) ? g : 8'($urandom_range(0, 255));
         pv[d] = 1'b1;
         pd[d] = gv;
         acc = 1'b0;
         c   = 0;
         while (!acc && c < 200) begin
            @(negedge clk);
            c++;
            acc = pv[d] && pr[d];
         end
         if (!acc) begin
            chk("pix_accept_timeout", 32'd0, 32'd1);
            pv[d] = 1'b0;
            return;
         end
         if (bx[d] % 8 == 0) begin
            chk("x_coord", 32'(xo[d]), 32'(bx[d]));
            chk("y_coord", 32'(yo[d]), 32'(by[d]));
            gaddr[d] = by[d] * (hact / 8) + bx[d] / 8;
         end
         b      = (gv[7:2] > bayer(bx[d], by[d]));
         grp[d] = {grp[d][6:0], b};
         if (bx[d] % 8 == 7) begin
            e.last = (bx[d] == hact - 1) && (by[d] == vact - 1);
            e.addr = 14'(gaddr[d]);
            e.data = grp[d];
            push_exp(d, e);
         end
         if (bx[d] == hact - 1) begin
            bx[d] = 0;
            by[d]++;
         end else begin
            bx[d]++;
         end
         @(posedge clk); #1;
      end
      pv[d] = 1'b0;
   endtask

   task automatic wait_done(input int d, input int budget);
      int c;
      c = 0;
      while (!dn[d] && c < budget) begin
         @(negedge clk);
         c++;
      end
      if (!dn[d])
         chk("done_timeout", 32'd0, 32'd1);
      @(negedge clk);
      chk("busy_after_done", 32'(bz[d]), 32'd0);
   endtask

   initial begin
      logic got;
      int   c;
      rst_n = 1'b0;
      ff_mode = 1'b0;
      for (int d = 0; d < 2; d++) begin
         st[d] = 1'b0; ab[d] = 1'b0; pv[d] = 1'b0; pd[d] = '0; wr_rdy[d] = 1'b1;
         exp_done[d] = 1'b0; wr_cnt[d] = 0; acc_cnt[d] = 0;
         bx[d] = 0; by[d] = 0; grp[d] = '0; gaddr[d] = 0;
      end
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // reset values after 10 idle cycles
      repeat (10) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("rst_busy", 32'(bz[d]), 32'd0);
         chk("rst_done", 32'(dn[d]), 32'd0);
         chk("rst_pix_ready", 32'(pr[d]), 32'd0);
         chk("rst_x", 32'(xo[d]), 32'd0);
         chk("rst_y", 32'(yo[d]), 32'd0);
         chk("rst_wr_valid", 32'(wv[d]), 32'd0);
         chk("rst_wr_addr", 32'(wa[d]), 32'd0);
         chk("rst_wr_data", 32'(wd[d]), 32'd0);
      end

      // 16x2 frame, gray 0x00
      c0 = wr_cnt[0];
      start_frame(0);
      drive(0, 32, 0, 8'h00);
      wait_done(0, 100);
      chk("wr_cnt_gray00", 32'(wr_cnt[0] - c0), 32'd4);

      // 16x2 frame, gray 0x80
      for (int i = 0; i < 4; i++) seen0[i] = 8'h11;
      start_frame(0);
      drive(0, 32, 0, 8'h80);
      wait_done(0, 100);
      chk("gray80_b0", 32'(seen0[0]), 32'hAA);
      chk("gray80_b1", 32'(seen0[1]), 32'hAA);
      chk("gray80_b2", 32'(seen0[2]), 32'h55);
      chk("gray80_b3", 32'(seen0[3]), 32'h55);

      // output stall for 20 cycles with random gray
      c0 = wr_cnt[0];
      start_frame(0);
      fork
         drive(0, 32, 1, 8'h00);
         begin
            got = 1'b0;
            c   = 0;
            while (!got && c < 100) begin
               @(posedge clk); #1;
               c++;
               got = wv[0];
            end
            if (!got) begin
               chk("stall_wr_valid_timeout", 32'd0, 32'd1);
            end else begin
               wr_rdy[0] = 1'b0;
               sa = wa[0];
               sd = wd[0];
               a0 = acc_cnt[0];
               for (int k = 0; k < 20; k++) begin
                  @(posedge clk); #1;
               end
               chk("stall_addr_stable", 32'(wa[0]), 32'(sa));
               chk("stall_data_stable", 32'(wd[0]), 32'(sd));
               chk("stall_accepts", 32'(acc_cnt[0] - a0), 32'd7);
               chk("stall_pix_ready", 32'(pr[0]), 32'd0);
               wr_rdy[0] = 1'b1;
            end
         end
      join
      wait_done(0, 100);
      chk("stall_wr_cnt", 32'(wr_cnt[0] - c0), 32'd4);

      // abort mid-line; start pulsed while busy must be ignored
      c0 = wr_cnt[0];
      start_frame(0);
      fork
         drive(0, 12, 1, 8'h00);
         begin
            for (int k = 0; k < 4; k++) begin
               @(posedge clk); #1;
            end
            st[0] = 1'b1;
            @(posedge clk); #1;
            st[0] = 1'b0;
         end
      join
      chk("busy_start_x", 32'(xo[0]), 32'd12);
      chk("busy_start_y", 32'(yo[0]), 32'd0);
      @(posedge clk); #1;
      ab[0] = 1'b1;
      @(posedge clk); #1;
      ab[0] = 1'b0;
      chk("abort_wr_valid", 32'(wv[0]), 32'd0);
      chk("abort_busy", 32'(bz[0]), 32'd0);
      chk("abort_pix_ready", 32'(pr[0]), 32'd0);
      chk("abort_queue_empty", 32'(q0.size()), 32'd0);
      chk("abort_wr_cnt", 32'(wr_cnt[0] - c0), 32'd1);
      repeat (5) @(negedge clk);
      start_frame(0);
      drive(0, 32, 0, 8'h00);
      wait_done(0, 100);

      // full 320x240 frame, gray 0xFF
      ff_mode = 1'b1;
      c1 = wr_cnt[1];
      start_frame(1);
      drive(1, 320 * 240, 0, 8'hFF);
      wait_done(1, 200);
      ff_mode = 1'b0;
      chk("full_wr_cnt", 32'(wr_cnt[1] - c1), 32'd9600);
      chk("queue_s_empty", 32'(q0.size()), 32'd0);
      chk("queue_f_empty", 32'(q1.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
